// File: rtl/debounce_pkg.sv
// Shared types and helpers for the button debouncer bank.
package debounce_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_DELAY,
    RPT_REPEAT
  } repeat_state_e;

  // Counter width for a modulus, never less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer channel: synchroniser, tick-driven stability filter,
// registered press/release pulses and an optional auto-repeat FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 0,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sig_in,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int SW      = clog2_min1(STABLE_SAMPLES);
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = clog2_min1(RPT_MAX);

  localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_SAMPLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST   = RW'(REPEAT_RATE - 1);
  localparam logic          INVERT      = (ACTIVE_LOW != 0);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [SW-1:0] stable_cnt_q, stable_cnt_d;
  logic          pressed_q, pressed_d;
  logic          released_q, released_d;
  repeat_state_e rpt_state_q, rpt_state_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          level_rise, level_fall, repeat_fire;

  // Stability filter: Level flips only after STABLE_SAMPLES disagreeing ticks.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    level_d      = level_q;
    stable_cnt_d = stable_cnt_q;
    if (tick) begin
      if (sync2_q == level_q) begin
        stable_cnt_d = '0;
      end else if (stable_cnt_q == STABLE_LAST) begin
        level_d      = ~level_q;
        stable_cnt_d = '0;
      end else begin
        stable_cnt_d = stable_cnt_q + 1'b1;
      end
    end
  end

  assign level_rise = level_d & ~level_q;
  assign level_fall = ~level_d & level_q;

  // Repeat FSM next state; a falling Level always wins over a pending tick.
  always_comb begin
    rpt_state_d = rpt_state_q;
    rpt_cnt_d   = rpt_cnt_q;
    case (rpt_state_q)
      RPT_IDLE: begin
        if (level_rise) begin
          rpt_state_d = RPT_DELAY;
          rpt_cnt_d   = '0;
        end
      end
      RPT_DELAY: begin
        if (level_fall) begin
          rpt_state_d = RPT_IDLE;
          rpt_cnt_d   = '0;
        end else if (tick) begin
          if (rpt_cnt_q == DELAY_LAST) begin
            rpt_state_d = RPT_REPEAT;
            rpt_cnt_d   = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
      end
      RPT_REPEAT: begin
        if (level_fall) begin
          rpt_state_d = RPT_IDLE;
          rpt_cnt_d   = '0;
        end else if (tick) begin
          rpt_cnt_d = (rpt_cnt_q == RATE_LAST) ? '0 : rpt_cnt_q + 1'b1;
        end
      end
      default: begin
        rpt_state_d = RPT_IDLE;
        rpt_cnt_d   = '0;
      end
    endcase
    if (REPEAT_EN == 0) begin
      rpt_state_d = RPT_IDLE;
      rpt_cnt_d   = '0;
    end
  end

  always_comb begin
    repeat_fire = 1'b0;
    if (tick && !level_fall) begin
      case (rpt_state_q)
        RPT_DELAY:  repeat_fire = (rpt_cnt_q == DELAY_LAST);
        RPT_REPEAT: repeat_fire = (rpt_cnt_q == RATE_LAST);
        default:    repeat_fire = 1'b0;
      endcase
    end
    pressed_d  = level_rise | repeat_fire;
    released_d = level_fall;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      stable_cnt_q <= '0;
      pressed_q    <= 1'b0;
      released_q   <= 1'b0;
      rpt_state_q  <= RPT_IDLE;
      rpt_cnt_q    <= '0;
    end else begin
      sync1_q      <= sig_in ^ INVERT;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      stable_cnt_q <= stable_cnt_d;
      pressed_q    <= pressed_d;
      released_q   <= released_d;
      rpt_state_q  <= rpt_state_d;
      rpt_cnt_q    <= rpt_cnt_d;
    end
  end

  assign level    = level_q;
  assign pressed  = pressed_q;
  assign released = released_q;

endmodule

// File: rtl/button_debouncer_bank.sv
// Multi-channel button debouncer: a shared sample-tick prescaler driving
// CHANNELS independent debounce_channel instances.
module button_debouncer_bank
  import debounce_pkg::*;
#(
  parameter int CHANNELS       = 5,
  parameter int SAMPLE_PERIOD  = 20000,
  parameter int STABLE_SAMPLES = 3,
  parameter int ACTIVE_LOW     = 0,
  parameter int REPEAT_EN      = 0,
  parameter int REPEAT_DELAY   = 25,
  parameter int REPEAT_RATE    = 8
) (
  input  logic                Clock,
  input  logic                Reset_n,
  input  logic [CHANNELS-1:0] Signal,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] Pressed,
  output logic [CHANNELS-1:0] Released
);

  localparam int              PW         = clog2_min1(SAMPLE_PERIOD);
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SAMPLE_PERIOD - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic          tick;

  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Reset_n) presc_q <= '0;
    else          presc_q <= presc_d;
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    debounce_channel #(
      .STABLE_SAMPLES (STABLE_SAMPLES),
      .ACTIVE_LOW     (ACTIVE_LOW),
      .REPEAT_EN      (REPEAT_EN),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE)
    ) u_chan (
      .clk      (Clock),
      .rst_n    (Reset_n),
      .tick     (tick),
      .sig_in   (Signal[ch]),
      .level    (Level[ch]),
      .pressed  (Pressed[ch]),
      .released (Released[ch])
    );
  end

endmodule

// File: doc/button_debouncer_bank.md
Name: button_debouncer_bank

Overview:
Parametrised multi-channel debouncer for the front-panel buttons feeding the game controller. Each channel has its own synchroniser, a stability filter clocked by one shared sample tick, a debounced level, one-cycle press and release pulses, and optional auto-repeat of press pulses while a button is held. Replaces per-button single-channel debouncers; the game FSM consumes the Pressed pulses directly.

Parameters:
CHANNELS, 5, number of independent input channels (>=1)
SAMPLE_PERIOD, 20000, clock cycles between sample ticks (>=1)
STABLE_SAMPLES, 3, consecutive disagreeing ticks needed to change Level (>=1)
ACTIVE_LOW, 0, 1 = inputs are inverted before synchronisation (pull-up buttons)
REPEAT_EN, 0, 1 = enable auto-repeat of Pressed while held
REPEAT_DELAY, 25, ticks held before the first repeat pulse (>=1)
REPEAT_RATE, 8, ticks between subsequent repeat pulses (>=1)

Ports:
Clock  input  1  system clock; all state changes on rising edge
Reset_n  input  1  synchronous, active-low reset
Signal  input  CHANNELS  raw asynchronous button inputs
Level  output  CHANNELS  debounced, registered level (1 = pressed)
Pressed  output  CHANNELS  one-cycle pulse on debounced press and on each repeat
Released  output  CHANNELS  one-cycle pulse on debounced release

Behaviour:
- Reset (Reset_n=0 at an edge): prescaler=0, sync flops=0, Level=0, Pressed=0, Released=0, all filter/repeat counters=0, repeat state=IDLE. No pulses are generated by reset itself, including reset while Level=1.
- Input conditioning: s = Signal ^ {CHANNELS{ACTIVE_LOW}}; two-flop synchroniser per channel; the filter sees sync stage 2 (2-cycle latency).
- Prescaler: counts 0..SAMPLE_PERIOD-1 and wraps. tick=1 in the cycle where count==SAMPLE_PERIOD-1. With SAMPLE_PERIOD=1, tick=1 every cycle. Width is $clog2(SAMPLE_PERIOD), minimum 1.
- Filter (per channel; acts only in tick cycles):
  - Synced value == Level: stable counter cleared.
  - Synced value != Level and counter == STABLE_SAMPLES-1: Level toggles and the counter clears.
  - Synced value != Level otherwise: counter increments.
  - Non-tick cycles hold all filter state.
- Pulses: Pressed/Released are registered and updated at the same edge as Level. Pressed=1 in the first cycle Level reads 1. Released=1 in the first cycle Level reads 0. Both are otherwise 0, and they never assert together on one channel.
- Repeat FSM (per channel; only when REPEAT_EN=1, else held in IDLE):
  - IDLE -> DELAY on Level rise, repeat counter=0.
  - DELAY, on a tick:
    - counter==REPEAT_DELAY-1: Pressed pulse, go to REPEAT, counter=0.
    - otherwise: counter++.
  - REPEAT, on a tick:
    - counter==REPEAT_RATE-1: Pressed pulse, counter=0.
    - otherwise: counter++.
  - Any state -> IDLE at the same edge Level falls. A repeat pulse is never emitted at that edge.
  - The tick that causes the Level rise does not advance the repeat counter.
- Channels are fully independent. Simultaneous events on different channels all produce their pulses in the same cycle.
- Counter widths are derived with $clog2. No wrap-around is possible beyond the stated terminal counts.

Decomposition:
- Shared package debounce_pkg:
  - repeat-state enum (IDLE, DELAY, REPEAT)
  - a width helper function (clog2 with minimum 1)
- Sub-module debounce_channel: synchroniser, filter, pulse regs and repeat FSM for one channel. It takes tick as an input and is instantiated CHANNELS times via generate.
- Top level holds the prescaler only.

Test Plan:
(All scenarios use CHANNELS=4, SAMPLE_PERIOD=4, STABLE_SAMPLES=3, REPEAT_EN=1, REPEAT_DELAY=5, REPEAT_RATE=2. Cycle 0 is the first cycle after Reset_n returns high; ticks occur in cycles 3, 7, 11, ...)
1. Clean press: Signal[0]=1 from cycle 0 -> Level[0]=1 and Pressed[0]=1 in cycle 12 only; other channels stay 0.
2. Auto-repeat: keep Signal[0]=1 -> further Pressed[0] pulses in cycles 32, 40 and 48, each 1 cycle wide, none elsewhere.
3. Glitch rejection: Signal[1]=1 for cycles 0-5 only -> Level[1], Pressed[1] and Released[1] stay 0 throughout.
4. Release: after scenario 1, drop Signal[0] at cycle 50 -> Released[0]=1 and Level[0]=0 in cycle 64; no Pressed[0] at or after cycle 64.
5. Reset mid-hold: with Level[0]=1, hold Reset_n=0 for one edge -> all outputs 0 with no Released pulse. With Signal[0] still 1, Pressed[0] reasserts 12 cycles after reset release.
6. ACTIVE_LOW=1: Signal held at 4'b1111 through and after reset -> no pulses. Drive Signal[2]=0 at cycle 0 -> Pressed[2] in cycle 12.
